amp_seq: RTL and testbench
==========================

Name: amp_seq

Overview:
- Power-up and configuration sequencer for the external class-D amplifier.
- Controls amp_nenable and amp_mute, waits for amplifier power-up, then writes a 4-entry register table over the amp I2C bus (the block is the I2C master).
- Unmutes only after every write was ACKed; runs a mute-then-disable shutdown.
- Instanced in the tinytapeout top next to the register bank, which supplies enable, mute and the config table through sys_cfg fields.

Parameters:
CLK_DIV, 8, clk cycles per SCL quarter-bit (bit period = 4*CLK_DIV)
PWRUP_WAIT, 1024, clk cycles from amp_nenable low to first START
MUTE_WAIT, 256, clk cycles from amp_mute high to amp_nenable high on shutdown
AMP_ADDR, 7'h2C, 7-bit amplifier I2C slave address
N_CFG, 4, number of register writes in the table

Ports:
clk  in  1  system clock
resetb  in  1  asynchronous active-low reset
enable  in  1  run request (level)
mute_req  in  1  soft mute request while running
cfg_addr  in  8*N_CFG  amp register addresses; entry i = bits [8i+7:8i]
cfg_data  in  8*N_CFG  amp register data; same packing
amp_i2c_scl  out  1  SCL, push-pull, idle 1
amp_i2c_sdai  in  1  SDA sampled from pad
amp_i2c_sdao  out  1  constant 0 (open-drain)
amp_i2c_sdaoe  out  1  1 = pull SDA low, 0 = release
amp_nenable  out  1  amplifier enable, active low
amp_mute  out  1  amplifier mute, active high
busy  out  1  high in any state except IDLE, RUN, ERROR
nack_err  out  1  sticky, set on any NACK
state_mon  out  3  current FSM state encoding

Behaviour:
- Reset: SCL=1, sdaoe=0, sdao=0, amp_nenable=1, amp_mute=1, busy=0, nack_err=0, state IDLE, all counters 0.
- States: IDLE(0), PWRUP(1), CFG(2), RUN(3), SHUTDN(4), ERROR(5).
- IDLE: enable=1 -> PWRUP. amp_nenable drops to 0 on the same edge; the wait counter clears.
- PWRUP: counts PWRUP_WAIT cycles -> CFG with entry index 0.
- CFG: one transaction per entry, in this order:
  - START
  - byte {AMP_ADDR,0}, ACK bit
  - byte cfg_addr[i], ACK bit
  - byte cfg_data[i], ACK bit
  - STOP
  - If entries remain, index+1 and the next transaction begins on the next cycle.
  - After entry N_CFG-1 -> RUN.
- cfg_addr/cfg_data are sampled at the byte load. Software must not change them while busy.
- RUN: amp_mute = mute_req, registered (1 cycle latency). enable=0 -> SHUTDN.
- SHUTDN: amp_mute=1 immediately, counts MUTE_WAIT, then amp_nenable=1 -> IDLE.
- enable falling in PWRUP: go to SHUTDN directly.
- enable falling in CFG: the current transaction completes through STOP, then SHUTDN. Remaining entries are skipped.
- NACK (SDA sampled 1 in any ACK slot):
  - nack_err=1 and the remaining bytes of that transaction are skipped.
  - STOP is issued, then ERROR.
- ERROR: amp_mute=1, amp_nenable=1. Stays until enable=0, which clears nack_err and returns to IDLE.
- I2C timing (q = CLK_DIV cycles):
  - START: SDA falls while SCL=1; SCL falls q later.
  - Each bit = 4 quarters: SDA set in q0 with SCL low; SCL high for q1-q2; SDA sampled at end of q1; SCL low in q3.
  - Data is MSB first.
  - In ACK slots SDA is released and sampled like data.
  - STOP: SDA low, SCL high, then SDA released after q; the bus idles ≥4q before the next START.
- Transaction length = 2q + 27*4q + 2q + 4q idle.
- Asynchronous reset mid-transaction returns outputs to reset values immediately. There is no bus recovery; the slave resyncs on the next START.

Decomposition:
- Shared package (toi2s_pkg) holds:
  - amp_seq_state_t enum (3-bit, values above)
  - i2c_cmd_t enum {CMD_START, CMD_WRITE, CMD_STOP}
- Sub-module amp_i2c_master does bit timing and open-drain drive only.
  - Inputs: cmd_valid, cmd (i2c_cmd_t), wdata[7:0]
  - Outputs: cmd_ready, ack_n (valid with cmd_ready after a WRITE), scl, sdaoe
  - A command is accepted on cmd_valid & cmd_ready.
- amp_seq holds the FSM, wait counters and table indexing.

Test Plan:
- Power-up: CLK_DIV=2, PWRUP_WAIT=16, enable=1, ACKing slave model, cfg = {(0x00,0x01),(0x05,0x80),(0x10,0x3F),(0x11,0x3F)} -> amp_nenable low 1 cycle after enable, first START 16 cycles later, slave logs exactly 4 writes addr 0x2C with those pairs, then state RUN, amp_mute=0, busy=0.
- Mute in RUN: toggle mute_req 0->1->0 -> amp_mute follows with 1-cycle latency, no bus activity.
- Shutdown from RUN: enable=0 -> amp_mute=1 next cycle, amp_nenable=1 after MUTE_WAIT cycles, state IDLE.
- NACK: slave NACKs the data byte of entry 2 -> nack_err=1, STOP seen, no entry-3 transaction, state ERROR with mute=1, nenable=1; enable=0 -> nack_err=0, IDLE.
- Abort mid-CFG: enable=0 during entry 1 address byte -> entry 1 finishes with STOP, entries 2-3 absent, SHUTDN then IDLE.
- Async reset during an SCL-high phase -> scl=1, sdaoe=0, nenable=1, mute=1 within the reset assertion, without waiting for a clk edge.

Source files
------------

// File: rtl/toi2s_pkg.sv
// Shared types for the amplifier sequencer and its I2C bit engine.
package toi2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_CFG    = 3'd2,
    ST_RUN    = 3'd3,
    ST_SHUTDN = 3'd4,
    ST_ERROR  = 3'd5
  } amp_seq_state_t;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_STOP  = 2'd2
  } i2c_cmd_t;

endpackage

// File: rtl/amp_i2c_master.sv
// I2C write-only bit engine: START / byte+ACK / STOP with quarter-bit timing.
// SDA is open-drain (sdaoe=1 pulls low); SCL is push-pull.
module amp_i2c_master
  import toi2s_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic      clk,
  input  logic      resetb,
  input  logic      cmd_valid,
  input  i2c_cmd_t  cmd,
  input  logic [7:0] wdata,
  input  logic      sdai,
  output logic      cmd_ready,
  output logic      ack_n,
  output logic      scl,
  output logic      sdaoe
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_START = 3'd1;
  localparam logic [2:0] PH_BIT   = 3'd2;
  localparam logic [2:0] PH_STOP  = 3'd3;
  localparam logic [2:0] PH_GAP   = 3'd4;

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LOAD = QW'(CLK_DIV - 1);

  logic [2:0]    phase;
  logic [QW-1:0] q_cnt;
  logic [1:0]    qtr;
  logic [3:0]    bit_idx;
  logic [6:0]    shreg;
  logic          q_end;

  assign q_end     = (q_cnt == '0);
  assign cmd_ready = (phase == PH_IDLE);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      phase   <= PH_IDLE;
      q_cnt   <= '0;
      qtr     <= 2'd0;
      bit_idx <= 4'd0;
      shreg   <= 7'd0;
      scl     <= 1'b1;
      sdaoe   <= 1'b0;
      ack_n   <= 1'b0;
    end else if (phase == PH_IDLE) begin
      if (cmd_valid) begin
        q_cnt <= Q_LOAD;
        qtr   <= 2'd0;
        case (cmd)
          CMD_START: begin
            phase <= PH_START;
            scl   <= 1'b1;
            sdaoe <= 1'b1;
          end
          CMD_WRITE: begin
            phase   <= PH_BIT;
            bit_idx <= 4'd0;
            shreg   <= wdata[6:0];
            sdaoe   <= ~wdata[7];
            scl     <= 1'b0;
          end
          CMD_STOP: begin
            phase <= PH_STOP;
            scl   <= 1'b0;
            sdaoe <= 1'b1;
          end
          default: ;
        endcase
      end
    end else if (!q_end) begin
      q_cnt <= q_cnt - 1'b1;
    end else begin
      q_cnt <= Q_LOAD;
      qtr   <= qtr + 2'd1;
      case (phase)
        PH_START: begin
          if (qtr == 2'd0) scl <= 1'b0;
          else             phase <= PH_IDLE;
        end
        PH_BIT: begin
          case (qtr)
            2'd0: scl <= 1'b1;
            2'd1: if (bit_idx == 4'd8) ack_n <= sdai;
            2'd2: scl <= 1'b0;
            default: begin
              if (bit_idx == 4'd8) begin
                phase <= PH_IDLE;
              end else begin
                bit_idx <= bit_idx + 4'd1;
                // the ninth slot is the slave's ACK, so SDA is released there
                sdaoe   <= (bit_idx == 4'd7) ? 1'b0 : ~shreg[6];
                shreg   <= {shreg[5:0], 1'b0};
              end
            end
          endcase
        end
        PH_STOP: begin
          if (qtr == 2'd0) begin
            scl <= 1'b1;
          end else begin
            sdaoe <= 1'b0;
            phase <= PH_GAP;
            qtr   <= 2'd0;
          end
        end
        PH_GAP: if (qtr == 2'd3) phase <= PH_IDLE;
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/amp_seq.sv
// Class-D amplifier power/config sequencer: enable, power-up wait, I2C register
// table download, mute control and mute-then-disable shutdown.
//
// state  | meaning
// IDLE   | amp disabled and muted, waiting for enable
// PWRUP  | amp enabled, waiting for its supplies to settle
// CFG    | writing the register table over I2C
// RUN    | configured, mute follows mute_req
// SHUTDN | muted, waiting before disabling the amp
// ERROR  | a write was NACKed; held off until enable drops
module amp_seq
  import toi2s_pkg::*;
#(
  parameter int         CLK_DIV    = 8,
  parameter int         PWRUP_WAIT = 1024,
  parameter int         MUTE_WAIT  = 256,
  parameter logic [6:0] AMP_ADDR   = 7'h2C,
  parameter int         N_CFG      = 4
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               enable,
  input  logic               mute_req,
  input  logic [8*N_CFG-1:0] cfg_addr,
  input  logic [8*N_CFG-1:0] cfg_data,
  output logic               amp_i2c_scl,
  input  logic               amp_i2c_sdai,
  output logic               amp_i2c_sdao,
  output logic               amp_i2c_sdaoe,
  output logic               amp_nenable,
  output logic               amp_mute,
  output logic               busy,
  output logic               nack_err,
  output logic [2:0]         state_mon
);

  localparam int WAIT_MAX = (PWRUP_WAIT > MUTE_WAIT) ? PWRUP_WAIT : MUTE_WAIT;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int IW = (N_CFG > 1) ? $clog2(N_CFG) : 1;

  localparam logic [2:0] STEP_START = 3'd0;
  localparam logic [2:0] STEP_DEV   = 3'd1;
  localparam logic [2:0] STEP_REG   = 3'd2;
  localparam logic [2:0] STEP_DAT   = 3'd3;
  localparam logic [2:0] STEP_STOP  = 3'd4;
  localparam logic [2:0] STEP_DONE  = 3'd5;

  amp_seq_state_t state;
  logic [WW-1:0]  wait_cnt;
  logic [IW-1:0]  idx;
  logic [2:0]     step;
  logic [2:0]     eff_step;
  logic           ack_pend;
  logic           nack_now;
  logic           m_valid;
  logic           m_ready;
  logic           m_ack_n;
  i2c_cmd_t       m_cmd;
  logic [7:0]     m_wdata;
  logic [7:0]     addr_tab [N_CFG];
  logic [7:0]     data_tab [N_CFG];

  for (genvar g = 0; g < N_CFG; g++) begin : g_tab
    assign addr_tab[g] = cfg_addr[8*g +: 8];
    assign data_tab[g] = cfg_data[8*g +: 8];
  end

  // A NACK on the byte just sent diverts the next command straight to STOP.
  assign nack_now = ack_pend & m_ack_n & m_ready;
  assign eff_step = nack_now ? STEP_STOP : step;

  always_comb begin
    m_valid = (state == ST_CFG) && (eff_step <= STEP_STOP);
    m_cmd   = CMD_STOP;
    m_wdata = 8'h00;
    case (eff_step)
      STEP_START: m_cmd = CMD_START;
      STEP_DEV: begin
        m_cmd   = CMD_WRITE;
        m_wdata = {AMP_ADDR, 1'b0};
      end
      STEP_REG: begin
        m_cmd   = CMD_WRITE;
        m_wdata = addr_tab[idx];
      end
      STEP_DAT: begin
        m_cmd   = CMD_WRITE;
        m_wdata = data_tab[idx];
      end
      default: m_cmd = CMD_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      idx         <= '0;
      step        <= STEP_START;
      ack_pend    <= 1'b0;
      nack_err    <= 1'b0;
      amp_nenable <= 1'b1;
      amp_mute    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          amp_nenable <= 1'b1;
          amp_mute    <= 1'b1;
          if (enable) begin
            state       <= ST_PWRUP;
            amp_nenable <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        ST_PWRUP: begin
          if (!enable) begin
            state    <= ST_SHUTDN;
            amp_mute <= 1'b1;
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(PWRUP_WAIT - 2)) begin
            // one cycle less: the START itself is accepted on the next edge
            state    <= ST_CFG;
            idx      <= '0;
            step     <= STEP_START;
            ack_pend <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CFG: begin
          if (m_valid && m_ready) begin
            step     <= eff_step + 3'd1;
            ack_pend <= (m_cmd == CMD_WRITE);
            if (nack_now) nack_err <= 1'b1;
          end else if (step == STEP_DONE && m_ready) begin
            if (nack_err) begin
              state       <= ST_ERROR;
              amp_nenable <= 1'b1;
              amp_mute    <= 1'b1;
            end else if (!enable) begin
              state    <= ST_SHUTDN;
              wait_cnt <= '0;
            end else if (idx == IW'(N_CFG - 1)) begin
              state <= ST_RUN;
            end else begin
              idx  <= idx + 1'b1;
              step <= STEP_START;
            end
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state    <= ST_SHUTDN;
            amp_mute <= 1'b1;
            wait_cnt <= '0;
          end else begin
            amp_mute <= mute_req;
          end
        end
        ST_SHUTDN: begin
          amp_mute <= 1'b1;
          if (wait_cnt == WW'(MUTE_WAIT - 1)) begin
            state       <= ST_IDLE;
            amp_nenable <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_ERROR: begin
          amp_nenable <= 1'b1;
          amp_mute    <= 1'b1;
          if (!enable) begin
            state    <= ST_IDLE;
            nack_err <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  amp_i2c_master #(.CLK_DIV(CLK_DIV)) u_i2c (
    .clk       (clk),
    .resetb    (resetb),
    .cmd_valid (m_valid),
    .cmd       (m_cmd),
    .wdata     (m_wdata),
    .sdai      (amp_i2c_sdai),
    .cmd_ready (m_ready),
    .ack_n     (m_ack_n),
    .scl       (amp_i2c_scl),
    .sdaoe     (amp_i2c_sdaoe)
  );

  assign amp_i2c_sdao = 1'b0;
  assign busy         = (state == ST_PWRUP) || (state == ST_CFG) || (state == ST_SHUTDN);
  assign state_mon    = state;

endmodule

// File: tb/tb_amp_seq.sv
// Bench for amp_seq: behavioural I2C slave with per-transaction log, reference
// expectations for power-up, mute, shutdown, NACK, abort and async reset.
module tb_amp_seq;

  localparam int CLK_DIV    = 2;
  localparam int PWRUP_WAIT = 16;
  localparam int MUTE_WAIT  = 8;
  localparam int N_CFG      = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_PWRUP = 3'd1, S_CFG = 3'd2,
                         S_RUN = 3'd3, S_SHUTDN = 3'd4, S_ERROR = 3'd5;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic        mute_req = 1'b0;
  logic [31:0] cfg_addr_v = '0;
  logic [31:0] cfg_data_v = '0;
  logic        scl, sdao, sdaoe, nen, mute, busy, nack_err;
  logic [2:0]  state_mon;
  logic        s_pull = 1'b0;
  logic        sda_bus;

  assign sda_bus = ~(sdaoe | s_pull);

  always #5 clk = ~clk;

  amp_seq #(
    .CLK_DIV(CLK_DIV), .PWRUP_WAIT(PWRUP_WAIT), .MUTE_WAIT(MUTE_WAIT),
    .AMP_ADDR(7'h2C), .N_CFG(N_CFG)
  ) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .mute_req(mute_req),
    .cfg_addr(cfg_addr_v), .cfg_data(cfg_data_v),
    .amp_i2c_scl(scl), .amp_i2c_sdai(sda_bus), .amp_i2c_sdao(sdao),
    .amp_i2c_sdaoe(sdaoe), .amp_nenable(nen), .amp_mute(mute),
    .busy(busy), .nack_err(nack_err), .state_mon(state_mon)
  );

  // slave model and transaction log
  logic       p_scl = 1'b1, p_sda = 1'b1, in_txn = 1'b0;
  int         s_bit = 0, s_byte = 0, s_starts = 0;
  logic [7:0] s_shift = '0;
  logic [7:0] cur_b [3];
  int         nack_txn = -1, nack_byte = -1;
  int         log_n = 0;
  logic [7:0] log_b0 [64], log_b1 [64], log_b2 [64];
  int         log_nb [64];

  always @(scl or sda_bus) begin
    if (scl && p_scl && p_sda && !sda_bus) begin
      in_txn = 1'b1; s_bit = 0; s_byte = 0; s_starts++; s_pull = 1'b0;
      cur_b[0] = 8'hxx; cur_b[1] = 8'hxx; cur_b[2] = 8'hxx;
    end else if (scl && p_scl && !p_sda && sda_bus && in_txn) begin
      if (log_n < 64) begin
        log_b0[log_n] = cur_b[0]; log_b1[log_n] = cur_b[1];
        log_b2[log_n] = cur_b[2]; log_nb[log_n] = s_byte;
      end
      log_n++;
      in_txn = 1'b0;
    end else if (scl && !p_scl && in_txn) begin
      if (s_bit < 8) begin
        s_shift = {s_shift[6:0], sda_bus};
        s_bit++;
      end
    end else if (!scl && p_scl && in_txn) begin
      if (s_bit == 8) begin
        if (s_byte < 3) cur_b[s_byte] = s_shift;
        s_pull = !((s_starts - 1 == nack_txn) && (s_byte == nack_byte));
        s_bit = 9;
      end else if (s_bit == 9) begin
        s_pull = 1'b0;
        s_byte++;
        s_bit = 0;
      end
    end
    p_scl = scl;
    p_sda = sda_bus;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_mon !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, state_mon, s);
  endtask

  task automatic check_log(input int base, input int n, input int ne, input int nb);
    check_val("txn_count", log_n - base, n);
    for (int k = 0; k < n && base + k < 64 && base + k < log_n; k++) begin
      int e;
      e = (k == ne) ? nb + 1 : 3;
      check_val("txn_nbytes", log_nb[base+k], e);
      check_val("txn_dev", log_b0[base+k], 8'h58);
      if (e > 1) check_val("txn_reg", log_b1[base+k], cfg_addr_v[8*k +: 8]);
      if (e > 2) check_val("txn_dat", log_b2[base+k], cfg_data_v[8*k +: 8]);
    end
  endtask

  // ne/nb: entry and byte the slave NACKs (-1 none); ae: entry whose register
  // address byte sees enable drop (-1 none)
  task automatic run_seq(input int ne, input int nb, input int ae);
    int base, sbase, n;
    base  = log_n;
    sbase = s_starts;
    nack_txn  = (ne >= 0) ? sbase + ne : -1;
    nack_byte = nb;
    @(negedge clk);
    enable = 1'b1;
    if (ae >= 0) begin
      n = 0;
      while (!(s_starts - sbase == ae + 1 && s_byte == 1) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check_val("abort_sync", (s_starts - sbase == ae + 1 && s_byte == 1), 1);
      enable = 1'b0;
      wait_state(S_SHUTDN, 5000, "abort_shutdn");
      wait_state(S_IDLE, 100, "abort_idle");
      check_val("abort_nen", nen, 1'b1);
      check_log(base, ae + 1, -1, -1);
    end else if (ne >= 0) begin
      wait_state(S_ERROR, 5000, "nack_error");
      check_val("nack_err", nack_err, 1'b1);
      check_val("nack_mute", mute, 1'b1);
      check_val("nack_nen", nen, 1'b1);
      check_val("nack_busy", busy, 1'b0);
      check_val("nack_bus_idle", sda_bus, 1'b1);
      check_log(base, ne + 1, ne, nb);
      enable = 1'b0;
      @(negedge clk);
      check_val("err_exit_state", state_mon, S_IDLE);
      check_val("err_exit_nack", nack_err, 1'b0);
    end else begin
      wait_state(S_RUN, 5000, "run_reach");
      check_log(base, N_CFG, -1, -1);
      check_val("run_nack", nack_err, 1'b0);
      @(negedge clk);
      check_val("run_mute", mute, mute_req);
      enable = 1'b0;
      wait_state(S_IDLE, 100, "run_off");
    end
    nack_txn = -1;
  endtask

  initial begin
    int base, sbase, n;
    logic last, r;

    repeat (3) @(negedge clk);
    check_val("rst_scl", scl, 1'b1);
    check_val("rst_sdaoe", sdaoe, 1'b0);
    check_val("rst_sdao", sdao, 1'b0);
    check_val("rst_nen", nen, 1'b1);
    check_val("rst_mute", mute, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_nack", nack_err, 1'b0);
    check_val("rst_state", state_mon, S_IDLE);
    resetb = 1'b1;
    @(negedge clk);

    // directed power-up
    cfg_addr_v = 32'h11_10_05_00;
    cfg_data_v = 32'h3F_3F_80_01;
    base  = log_n;
    sbase = s_starts;
    enable = 1'b1;
    @(negedge clk);
    check_val("pu_nen", nen, 1'b0);
    check_val("pu_state", state_mon, S_PWRUP);
    check_val("pu_busy", busy, 1'b1);
    n = 0;
    while (!sdaoe && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("pu_start_delay", n, PWRUP_WAIT);
    check_val("pu_start_seen", s_starts - sbase, 1);
    wait_state(S_RUN, 5000, "pu_run");
    check_log(base, N_CFG, -1, -1);
    @(negedge clk);
    check_val("pu_mute", mute, 1'b0);
    check_val("pu_busy_run", busy, 1'b0);
    check_val("pu_nack", nack_err, 1'b0);

    // mute in RUN: one-cycle registered follow, bus stays idle
    sbase = s_starts;
    last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("mute_follow", mute, last);
      check_val("run_scl_idle", scl, 1'b1);
      r = 1'(($urandom_range(0, 3) == 0) ? ~last : last);
      if (i == 2) r = 1'b1;
      if (i == 4) r = 1'b0;
      mute_req = r;
      #1;
      check_val("mute_latency", mute, last);
      last = r;
    end
    @(negedge clk);
    check_val("mute_final", mute, last);
    check_val("run_no_start", s_starts - sbase, 0);
    mute_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("mute_clear", mute, 1'b0);

    // shutdown from RUN
    enable = 1'b0;
    @(negedge clk);
    check_val("sd_mute", mute, 1'b1);
    check_val("sd_state", state_mon, S_SHUTDN);
    check_val("sd_nen_low", nen, 1'b0);
    n = 0;
    while (!nen && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("sd_wait", n, MUTE_WAIT);
    check_val("sd_idle", state_mon, S_IDLE);

    // directed NACK on data byte of entry 2, then abort during entry 1
    run_seq(2, 2, -1);
    run_seq(-1, -1, 1);

    // randomized runs
    for (int it = 0; it < 6; it++) begin
      int mode;
      cfg_addr_v = $urandom;
      cfg_data_v = $urandom;
      mode = $urandom_range(0, 2);
      if (mode == 0)      run_seq(-1, -1, -1);
      else if (mode == 1) run_seq($urandom_range(0, 3), $urandom_range(0, 2), -1);
      else                run_seq(-1, -1, $urandom_range(0, 3));
    end

    // asynchronous reset while SCL is high mid-transaction
    sbase = s_starts;
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (!(s_starts > sbase && s_bit >= 2 && scl) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_val("ar_sync", (s_starts > sbase && s_bit >= 2 && scl), 1);
    #2;
    resetb = 1'b0;
    #1;
    check_val("ar_scl", scl, 1'b1);
    check_val("ar_sdaoe", sdaoe, 1'b0);
    check_val("ar_nen", nen, 1'b1);
    check_val("ar_mute", mute, 1'b1);
    check_val("ar_state", state_mon, S_IDLE);
    check_val("ar_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
